// File: rtl/uart_tx.sv
// uart_tx: frames parallel words onto an asynchronous serial line (8N1 by default).
// Ports: clk, rst (async, active-high), tx_data/tx_valid/tx_ready handshake in; txd, busy out.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY_ODD != 0);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data
        $error("uart_tx: DATA_W must be 5..9");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                par_bit;
    logic                bit_end;
    logic                stop_end;
    logic                handshake;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    // Last clk cycle of the last stop bit: accept the next word so
    // its start bit follows with no idle gap.
    assign stop_end  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    assign tx_ready  = (state == IDLE) || stop_end;
    assign handshake = tx_valid && tx_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else if (handshake) begin
            state    <= START;
            txd      <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= tx_data;
            // Parity is kept aside so the shifter can drain freely.
            par_bit  <= (^tx_data) ^ PAR_INV;
        end else begin
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        txd      <= shreg[0];
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with three build configurations.
// u0: 8N1, u1: 8E2, u2: 8O2; all at CLKS_PER_BIT = 4.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dat [3];
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] txd;
    logic [2:0] busy;

    int pass_cnt = 0;
    int total    = 0;
    int hs       = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0),
              .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]));

    uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1),
              .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]));

    uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1),
              .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]));

    task automatic chk(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h",
                    tag, idx, obs, exp);
    endtask

    // Present a word on instance u; counts the handshake the next edge sees.
    task automatic start(input int u, input logic [7:0] d);
        @(negedge clk);
        dat[u] = d;
        vld[u] = 1'b1;
        if (vld[u] && rdy[u]) hs++;
    endtask

    // Check nbits serial bits (4 clks each) of instance u against seq (bit i
    // = i-th bit on the line). After sample 0 drive (d1,v1); at the start of
    // a second frame drop tx_valid.
    task automatic watch(input string tag, input int u,
                         input logic [31:0] seq, input int nbits,
                         input int fbits, input logic [7:0] d1,
                         input logic v1);
        for (int i = 0; i < nbits * 4; i++) begin
            @(negedge clk);
            chk({tag, "_txd"}, i, 32'(txd[u]), 32'(seq[i / 4]));
            chk({tag, "_busy"}, i, 32'(busy[u]), 32'd1);
            chk({tag, "_rdy"}, i, 32'(rdy[u]),
                32'((i % (fbits * 4)) == (fbits * 4 - 1)));
            if (i == 0) begin
                dat[u] = d1;
                vld[u] = v1;
            end
            if (i == fbits * 4) vld[u] = 1'b0;
            if (vld[u] && rdy[u]) hs++;
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, 0, 32'({txd, rdy, busy}), 32'b111_111_000);
    endtask

    initial begin
        rst = 1'b1;
        vld = 3'b000;
        for (int k = 0; k < 3; k++) dat[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset", 0, 32'({txd, rdy, busy}), 32'b111_111_000);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", i, 32'({txd, rdy, busy}), 32'b111_111_000);
        end

        // 0xA5, then tx_data changed to 0x3C right after the handshake.
        hs = 0;
        start(0, 8'hA5);
        watch("a5", 0, 32'b1101001010, 10, 10, 8'h3C, 1'b0);
        chk("a5_hs", 0, 32'(hs), 32'd1);
        idle_chk("a5_after");

        // 0x00 then 0xFF back to back, tx_valid held high.
        hs = 0;
        start(0, 8'h00);
        watch("b2b", 0, {10'b1111111110, 10'b1000000000},
              20, 10, 8'hFF, 1'b1);
        chk("b2b_hs", 0, 32'(hs), 32'd2);
        idle_chk("b2b_after");

        // 0x07 with even parity (bit = 1) and two stop bits.
        start(1, 8'h07);
        watch("par_even", 1, 32'b111000001110, 12, 12, 8'h00, 1'b0);
        idle_chk("par_even_after");

        // 0x07 with odd parity (bit = 0) and two stop bits.
        start(2, 8'h07);
        watch("par_odd", 2, 32'b110000001110, 12, 12, 8'h00, 1'b0);
        idle_chk("par_odd_after");

        // Abort 0x5A during its 3rd data bit (a 0 on the line).
        start(0, 8'h5A);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) vld[0] = 1'b0;
        end
        chk("pre_rst_txd", 0, 32'(txd[0]), 32'd0);
        chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async", 0, 32'({txd[0], rdy[0], busy[0]}), 32'b110);
        @(negedge clk);
        rst = 1'b0;
        idle_chk("rst_after");

        start(0, 8'h55);
        watch("w55", 0, 32'b1010101010, 10, 10, 8'h00, 1'b0);
        idle_chk("w55_after");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
